// File: rtl/cv32e41p_apu_core_pkg.sv
// APU-side shared definitions for the cv32e41p FP reorder buffer.
// Holds the core flag width and the tag-width helper.
package cv32e41p_apu_core_pkg;

  localparam int APU_NUSFLAGS_CPU = 5;

  // Tag = {epoch bit, entry index}
  function automatic int rob_tag_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/cv32e41p_apu_reorder_buffer.sv
// Tag-tracking reorder buffer between the core APU port and an FP backend.
// Tags requests, collects out-of-order results, returns them in issue order.
// Ports: clk_i/rst_ni; core side apu_req_i/apu_gnt_o, apu_rvalid_o/apu_rready_i,
//   apu_rdata_o/apu_rflags_o, flush_i, busy_o; backend side fpu_in_valid_o/
//   fpu_in_ready_i/fpu_tag_o/fpu_flush_o, fpu_out_valid_i/fpu_out_ready_o/
//   fpu_tag_i/fpu_result_i/fpu_status_i.
module cv32e41p_apu_reorder_buffer
  import cv32e41p_apu_core_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int NUSFLAGS    = APU_NUSFLAGS_CPU,
  parameter bit BYPASS      = 1'b0,
  localparam int IDX_W      = $clog2(NUM_ENTRIES),
  localparam int TAG_W      = rob_tag_w(NUM_ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  apu_req_i,
  output logic                  apu_gnt_o,
  output logic                  apu_rvalid_o,
  input  logic                  apu_rready_i,
  output logic [DATA_WIDTH-1:0] apu_rdata_o,
  output logic [NUSFLAGS-1:0]   apu_rflags_o,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  fpu_in_valid_o,
  input  logic                  fpu_in_ready_i,
  output logic [TAG_W-1:0]      fpu_tag_o,
  output logic                  fpu_flush_o,
  input  logic                  fpu_out_valid_i,
  output logic                  fpu_out_ready_o,
  input  logic [TAG_W-1:0]      fpu_tag_i,
  input  logic [DATA_WIDTH-1:0] fpu_result_i,
  input  logic [NUSFLAGS-1:0]   fpu_status_i
);

  localparam logic [IDX_W:0] LP_FULL = (IDX_W+1)'(NUM_ENTRIES);

  logic [IDX_W-1:0]       r_alloc_ptr;
  logic [IDX_W-1:0]       r_head_ptr;
  logic [IDX_W:0]         r_count;
  logic                   r_epoch;
  logic [NUM_ENTRIES-1:0] r_alloc;
  logic [NUM_ENTRIES-1:0] r_done;
  logic [DATA_WIDTH-1:0]  r_data  [NUM_ENTRIES];
  logic [NUSFLAGS-1:0]    r_flags [NUM_ENTRIES];

  logic             w_full;
  logic             w_gnt;
  logic [IDX_W-1:0] w_wb_idx;
  logic             w_wb_ep;
  logic             w_wb_hit;
  logic             w_byp;
  logic             w_rvalid;
  logic             w_retire;
  logic             w_store;

  assign w_wb_idx = fpu_tag_i[IDX_W-1:0];
  assign w_wb_ep  = fpu_tag_i[IDX_W];

  // Full is judged on the registered count only, so a
  // same-cycle retire never opens issue (no rready->gnt path).
  assign w_full = (r_count == LP_FULL);

  assign fpu_in_valid_o  = apu_req_i & ~w_full & ~flush_i;
  assign w_gnt           = fpu_in_valid_o & fpu_in_ready_i;
  assign apu_gnt_o       = w_gnt;
  assign fpu_tag_o       = {r_epoch, r_alloc_ptr};
  assign fpu_flush_o     = flush_i;
  assign fpu_out_ready_o = 1'b1;

  // Results from an older epoch or for a free slot are dropped.
  assign w_wb_hit = fpu_out_valid_i & ~flush_i
                  & (w_wb_ep == r_epoch)
                  & r_alloc[w_wb_idx];

  assign w_byp = BYPASS & w_wb_hit
               & (w_wb_idx == r_head_ptr)
               & ~r_done[r_head_ptr];

  assign w_rvalid = (r_alloc[r_head_ptr] & r_done[r_head_ptr])
                  | w_byp;
  assign w_retire = w_rvalid & apu_rready_i & ~flush_i;

  // A bypassed result consumed in the same cycle is never stored.
  assign w_store = w_wb_hit & ~(w_byp & w_retire);

  assign apu_rvalid_o = w_rvalid;
  assign apu_rdata_o  = w_byp ? fpu_result_i
                              : r_data[r_head_ptr];
  assign apu_rflags_o = w_byp ? fpu_status_i
                              : r_flags[r_head_ptr];
  assign busy_o       = |r_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_alloc_ptr <= '0;
      r_head_ptr  <= '0;
      r_count     <= '0;
      r_epoch     <= 1'b0;
      r_alloc     <= '0;
      r_done      <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_data[i]  <= '0;
        r_flags[i] <= '0;
      end
    end else if (flush_i) begin
      r_alloc_ptr <= '0;
      r_head_ptr  <= '0;
      r_count     <= '0;
      r_epoch     <= ~r_epoch;
      r_alloc     <= '0;
      r_done      <= '0;
    end else begin
      if (w_gnt) begin
        r_alloc[r_alloc_ptr] <= 1'b1;
        r_done[r_alloc_ptr]  <= 1'b0;
        r_alloc_ptr          <= r_alloc_ptr + 1'b1;
      end
      if (w_store) begin
        r_done[w_wb_idx]  <= 1'b1;
        r_data[w_wb_idx]  <= fpu_result_i;
        r_flags[w_wb_idx] <= fpu_status_i;
      end
      if (w_retire) begin
        r_alloc[r_head_ptr] <= 1'b0;
        r_done[r_head_ptr]  <= 1'b0;
        r_head_ptr          <= r_head_ptr + 1'b1;
      end
      if (w_gnt && !w_retire) begin
        r_count <= r_count + 1'b1;
      end else if (!w_gnt && w_retire) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  a_count_max: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    r_count <= LP_FULL);

  a_wb_free: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (fpu_out_valid_i & ~flush_i & (w_wb_ep == r_epoch))
      |-> r_alloc[w_wb_idx]);

  a_rvalid_stable: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (w_rvalid & ~apu_rready_i & ~flush_i)
      |=> (w_rvalid & $stable(apu_rdata_o)
                    & $stable(apu_rflags_o)));

endmodule

// File: tb/tb_cv32e41p_apu_reorder_buffer.sv
// Self-checking bench for cv32e41p_apu_reorder_buffer.
// Table vectors for issue logic, scoreboard for in-order return.
module tb_cv32e41p_apu_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, gnt, rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [4:0]  rflags;
  logic        flush = 1'b0, busy;
  logic        in_valid, in_ready = 1'b1;
  logic [2:0]  tag_o;
  logic        flush_o;
  logic        out_valid = 1'b0, out_ready;
  logic [2:0]  tag_i = '0;
  logic [31:0] result = '0;
  logic [4:0]  status = '0;

  logic        b_req = 1'b0, b_gnt, b_rvalid, b_rready = 1'b0;
  logic [31:0] b_rdata;
  logic [4:0]  b_rflags;
  logic        b_busy, b_in_valid, b_flush_o, b_out_ready;
  logic [2:0]  b_tag_o;
  logic        b_out_valid = 1'b0;
  logic [2:0]  b_tag_i = '0;
  logic [31:0] b_result = '0;
  logic [4:0]  b_status = '0;

  always #5 clk = ~clk;

  cv32e41p_apu_reorder_buffer #(.NUM_ENTRIES(4), .BYPASS(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .apu_req_i(req), .apu_gnt_o(gnt),
    .apu_rvalid_o(rvalid), .apu_rready_i(rready),
    .apu_rdata_o(rdata), .apu_rflags_o(rflags),
    .flush_i(flush), .busy_o(busy),
    .fpu_in_valid_o(in_valid), .fpu_in_ready_i(in_ready),
    .fpu_tag_o(tag_o), .fpu_flush_o(flush_o),
    .fpu_out_valid_i(out_valid), .fpu_out_ready_o(out_ready),
    .fpu_tag_i(tag_i), .fpu_result_i(result),
    .fpu_status_i(status));

  cv32e41p_apu_reorder_buffer #(.NUM_ENTRIES(4), .BYPASS(1'b1)) b_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .apu_req_i(b_req), .apu_gnt_o(b_gnt),
    .apu_rvalid_o(b_rvalid), .apu_rready_i(b_rready),
    .apu_rdata_o(b_rdata), .apu_rflags_o(b_rflags),
    .flush_i(1'b0), .busy_o(b_busy),
    .fpu_in_valid_o(b_in_valid), .fpu_in_ready_i(1'b1),
    .fpu_tag_o(b_tag_o), .fpu_flush_o(b_flush_o),
    .fpu_out_valid_i(b_out_valid), .fpu_out_ready_o(b_out_ready),
    .fpu_tag_i(b_tag_i), .fpu_result_i(b_result),
    .fpu_status_i(b_status));

  int total = 0;
  int bad   = 0;
  int n_gnt = 0;
  int n_ret = 0;

  function automatic void chk(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic [31:0] d;
    logic [4:0]  f;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] bk_d [4];
  logic [4:0]  bk_f [4];

  // Scoreboard: expected result chosen at grant, compared at retire
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (rvalid && rready && !flush) begin
        n_ret++;
        if (exp_q.size() == 0) begin
          chk("spurious_rvalid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rdata", rdata, e.d);
          chk("rflags", rflags, e.f);
        end
      end
      if (flush) exp_q.delete();
      if (gnt) begin
        exp_t e;
        e.d = $urandom;
        e.f = 5'($urandom_range(0, 31));
        exp_q.push_back(e);
        bk_d[tag_o[1:0]] = e.d;
        bk_f[tag_o[1:0]] = e.f;
        n_gnt++;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req = 0; flush = 0; out_valid = 0; rready = 0; in_ready = 1;
    b_req = 0; b_out_valid = 0; b_rready = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic cyc(input bit rq, input bit fl, input bit wv,
                     input int wt, input bit rr,
                     input int e_rv = -1, input int e_gnt = -1,
                     input int e_tag = -1, input int e_busy = -1);
    req = rq; flush = fl; out_valid = wv; rready = rr;
    tag_i = wt[2:0];
    result = bk_d[wt[1:0]];
    status = bk_f[wt[1:0]];
    @(negedge clk);
    if (e_rv >= 0)   chk("rvalid", rvalid, e_rv);
    if (e_gnt >= 0)  chk("gnt", gnt, e_gnt);
    if (e_tag >= 0)  chk("tag", tag_o, e_tag);
    if (e_busy >= 0) chk("busy", busy, e_busy);
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit req, rdy, fl;
    bit e_iv, e_gnt, e_busy;
    int e_tag;
  } vec_t;

  vec_t tbl[9];
  int   g0, r0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 1, 0, 0, 0};
    tbl[2] = '{1, 1, 0, 1, 1, 0, 0};
    tbl[3] = '{1, 1, 0, 1, 1, 1, 1};
    tbl[4] = '{1, 1, 1, 0, 0, 1, 2};
    tbl[5] = '{0, 1, 0, 0, 0, 0, 4};
    tbl[6] = '{1, 1, 0, 1, 1, 0, 4};
    tbl[7] = '{0, 1, 1, 0, 0, 1, 5};
    tbl[8] = '{0, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      bk_d[i] = '0;
      bk_f[i] = '0;
    end

    do_reset();
    @(negedge clk);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_valid", in_valid, 0);
    chk("rst_tag", tag_o, 0);
    chk("rst_flush_o", flush_o, 0);
    chk("rst_out_ready", out_ready, 1);
    chk("rst_rdata", rdata, 0);
    chk("rst_rflags", rflags, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      req = tbl[i].req; in_ready = tbl[i].rdy; flush = tbl[i].fl;
      @(negedge clk);
      chk($sformatf("v%0d_in_valid", i), in_valid, tbl[i].e_iv);
      chk($sformatf("v%0d_gnt", i), gnt, tbl[i].e_gnt);
      chk($sformatf("v%0d_tag", i), tag_o, tbl[i].e_tag);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("v%0d_flush_o", i), flush_o, tbl[i].fl);
      chk($sformatf("v%0d_rvalid", i), rvalid, 0);
      @(posedge clk); #1;
    end
    req = 0; flush = 0; in_ready = 1;

    // In-order return, results 2 cycles after issue
    do_reset();
    r0 = n_ret;
    cyc(1, 0, 0, 0, 1, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0, 1, 1);
    cyc(1, 0, 1, 0, 1, 0, 1, 2);
    cyc(0, 0, 1, 1, 1, 1);
    cyc(0, 0, 1, 2, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 0, -1, -1, 0);
    chk("inorder_retires", n_ret - r0, 3);

    // Out-of-order completion 2,0,1
    do_reset();
    r0 = n_ret;
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 1, 2, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 1, 1, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 0, -1, -1, 0);
    chk("ooo_retires", n_ret - r0, 3);

    // Full and back-pressure
    do_reset();
    g0 = n_gnt;
    cyc(1, 0, 0, 0, 0, -1, 1, 0);
    cyc(1, 0, 1, 0, 0, -1, 1, 1);
    cyc(1, 0, 1, 1, 0, -1, 1, 2);
    cyc(1, 0, 1, 2, 0, -1, 1, 3);
    cyc(1, 0, 1, 3, 0, -1, 0);
    chk("full_in_valid", in_valid, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 1, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 0, -1, -1, 0);
    chk("full_gnts", n_gnt - g0, 5);

    // Flush with a late stale writeback
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 1, 0, 0, 0, 0, 0, -1, 1);
    cyc(0, 0, 1, 0, 1, 0, -1, -1, 0);
    cyc(1, 0, 0, 0, 1, 0, 1, 4, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 4, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 0, -1, -1, 0);

    // Asynchronous reset with three entries outstanding
    do_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, -1, -1, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_rvalid", rvalid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_tag", tag_o, 0);
    chk("arst_rdata", rdata, 0);
    chk("arst_gnt", gnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(1, 0, 0, 0, 1, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 0, -1, -1, 0);

    // Bypass instance: head writeback forwarded same cycle
    do_reset();
    b_req = 1;
    @(negedge clk);
    chk("byp_gnt", b_gnt, 1);
    chk("byp_tag", b_tag_o, 0);
    @(posedge clk); #1 b_req = 0;
    @(posedge clk); #1;
    b_out_valid = 1; b_tag_i = 3'd0;
    b_result = 32'hCAFE_0123; b_status = 5'h15; b_rready = 1;
    @(negedge clk);
    chk("byp_rvalid", b_rvalid, 1);
    chk("byp_rdata", b_rdata, 32'hCAFE_0123);
    chk("byp_rflags", b_rflags, 5'h15);
    chk("byp_busy_same", b_busy, 1);
    @(posedge clk); #1 b_out_valid = 0;
    @(negedge clk);
    chk("byp_rvalid_after", b_rvalid, 0);
    chk("byp_busy_after", b_busy, 0);
    @(posedge clk); #1 b_rready = 0; b_req = 1;
    @(negedge clk);
    chk("byp2_tag", b_tag_o, 1);
    @(posedge clk); #1 b_req = 0;
    b_out_valid = 1; b_tag_i = 3'd1;
    b_result = 32'hDEAD_BEEF; b_status = 5'h0A;
    @(negedge clk);
    chk("byp2_rvalid", b_rvalid, 1);
    chk("byp2_rdata", b_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1 b_out_valid = 0; b_result = '0;
    b_rready = 1;
    @(negedge clk);
    chk("byp2_held_rvalid", b_rvalid, 1);
    chk("byp2_held_rdata", b_rdata, 32'hDEAD_BEEF);
    chk("byp2_held_rflags", b_rflags, 5'h0A);
    @(posedge clk); #1 b_rready = 0;
    @(negedge clk);
    chk("byp2_rvalid_after", b_rvalid, 0);
    chk("byp2_busy_after", b_busy, 0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
